// File: rtl/vaa_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// vaa_fetch_sequencer
//   Handshaked multi-byte instruction fetch sequencer. Holds the program
//   counter, fetches an opcode plus 0..2 operand bytes over a req/ack memory
//   port, and presents one complete instruction per valid/ready transfer.
//   Supports branch redirection and halting at instruction boundaries.
//
// Optional feature macro: VAA_FETCH_PERF_EN
//   Defined   : perf_instr / perf_wait are saturating 32-bit event counters.
//   Undefined : perf_instr / perf_wait are tied to zero, no counter logic.
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   mem_req/mem_addr     fetch request (held until ack) and its address (=pc)
//   mem_ack/mem_rdata    request accepted, fetched word valid this cycle
//   ir_valid/ir_ready    instruction handshake to decode/execute
//   ir_opcode            opcode byte
//   ir_operand           operands, first byte in the low half
//   ir_len               instruction length in bytes (1..3)
//   ir_pc                address of the opcode byte
//   redirect/redirect_pc restart fetch at redirect_pc
//   halt/halted          level halt request / sequencer parked in HALTED
//   pc_out               current pc (debug)
//   perf_instr/perf_wait issued instructions / memory wait cycles
// ---------------------------------------------------------------------------
module vaa_fetch_sequencer #(
  parameter int unsigned       DATA_W       = 8,
  parameter int unsigned       ADDR_W       = 16,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
  input  logic                clk,
  input  logic                reset,
  output logic                mem_req,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                ir_valid,
  input  logic                ir_ready,
  output logic [DATA_W-1:0]   ir_opcode,
  output logic [2*DATA_W-1:0] ir_operand,
  output logic [1:0]          ir_len,
  output logic [ADDR_W-1:0]   ir_pc,
  input  logic                redirect,
  input  logic [ADDR_W-1:0]   redirect_pc,
  input  logic                halt,
  output logic                halted,
  output logic [ADDR_W-1:0]   pc_out,
  output logic [31:0]         perf_instr,
  output logic [31:0]         perf_wait
);

  typedef enum logic [2:0] {
    S_BOOT     = 3'd0,
    S_FETCH_OP = 3'd1,
    S_FETCH_B1 = 3'd2,
    S_FETCH_B2 = 3'd3,
    S_ISSUE    = 3'd4,
    S_HALTED   = 3'd5
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] pc;
  logic              xfer;
  logic              redirect_act;
  logic              accept;
  logic [1:0]        op_len;

  // A word moves only when we are actually requesting.
  assign xfer         = mem_req & mem_ack;
  // Redirect is ignored during the single BOOT cycle.
  assign redirect_act = redirect & (state != S_BOOT);
  assign accept       = ir_valid & ir_ready;

  // Length from the opcode's top two bits: 00 -> 1, 01 -> 2, 1x -> 3.
  assign op_len = mem_rdata[DATA_W-1] ? 2'd3 :
                  (mem_rdata[DATA_W-2] ? 2'd2 : 2'd1);

  assign mem_addr = pc;
  assign pc_out   = pc;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_BOOT;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; redirect outranks every other transition.
  always_comb begin
    state_nxt = state;
    if (redirect_act) begin
      state_nxt = (state == S_HALTED) ? S_HALTED : S_FETCH_OP;
    end else begin
      case (state)
        S_BOOT:     state_nxt = S_FETCH_OP;
        S_FETCH_OP: if (xfer) state_nxt = (op_len == 2'd1) ? S_ISSUE : S_FETCH_B1;
        S_FETCH_B1: if (xfer) state_nxt = (ir_len == 2'd2) ? S_ISSUE : S_FETCH_B2;
        S_FETCH_B2: if (xfer) state_nxt = S_ISSUE;
        S_ISSUE:    if (accept) state_nxt = halt ? S_HALTED : S_FETCH_OP;
        S_HALTED:   if (!halt) state_nxt = S_FETCH_OP;
        default:    state_nxt = S_BOOT;
      endcase
    end
  end

  // Moore outputs decoded from the state register.
  always_comb begin
    mem_req  = 1'b0;
    ir_valid = 1'b0;
    halted   = 1'b0;
    case (state)
      S_FETCH_OP,
      S_FETCH_B1,
      S_FETCH_B2: mem_req  = 1'b1;
      S_ISSUE:    ir_valid = 1'b1;
      S_HALTED:   halted   = 1'b1;
      default:    ;
    endcase
  end

  // Program counter and instruction register; data acked alongside a
  // redirect is dropped because the redirect branch wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc         <= RESET_VECTOR;
      ir_opcode  <= '0;
      ir_operand <= '0;
      ir_len     <= 2'd1;
      ir_pc      <= '0;
    end else if (redirect_act) begin
      pc <= redirect_pc;
    end else if (xfer) begin
      pc <= pc + ADDR_W'(1);
      case (state)
        S_FETCH_OP: begin
          ir_opcode  <= mem_rdata;
          ir_pc      <= pc;
          ir_len     <= op_len;
          ir_operand <= '0;
        end
        S_FETCH_B1: ir_operand[DATA_W-1:0]        <= mem_rdata;
        S_FETCH_B2: ir_operand[2*DATA_W-1:DATA_W] <= mem_rdata;
        default:    ;
      endcase
    end
  end

`ifdef VAA_FETCH_PERF_EN
  localparam int unsigned       PERF_W   = 32;
  localparam logic [PERF_W-1:0] PERF_MAX = '1;

  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_instr <= '0;
      perf_wait  <= '0;
    end else begin
      if (accept && (perf_instr != PERF_MAX)) begin
        perf_instr <= perf_instr + PERF_W'(1);
      end
      if (mem_req && !mem_ack && (perf_wait != PERF_MAX)) begin
        perf_wait <= perf_wait + PERF_W'(1);
      end
    end
  end
`else
  assign perf_instr = '0;
  assign perf_wait  = '0;
`endif

endmodule

// File: tb/tb_vaa_fetch_sequencer.sv
`timescale 1ns/1ps
module tb_vaa_fetch_sequencer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        mem_req, mem_ack, ir_valid, ir_ready, redirect, halt, halted;
  logic [15:0] mem_addr, redirect_pc, ir_pc, pc_out, ir_operand;
  logic [7:0]  mem_rdata, ir_opcode;
  logic [1:0]  ir_len;
  logic [31:0] perf_instr, perf_wait;

  // second instance with RESET_VECTOR=FFFF, zero-wait memory
  logic        mem_req_w, ir_valid_w, halted_w;
  logic [15:0] mem_addr_w, ir_pc_w, pc_out_w, ir_operand_w;
  logic [7:0]  mem_rdata_w, ir_opcode_w;
  logic [1:0]  ir_len_w;
  logic [31:0] perf_instr_w, perf_wait_w;

  logic [7:0]  mem [0:65535];
  int          ack_delay = 0;
  int          wcnt = 0;

  int n_checks = 0;
  int n_err    = 0;

`ifdef VAA_FETCH_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // memory responder: ack after ack_delay waiting cycles of a request
  assign mem_rdata   = mem[mem_addr];
  assign mem_ack     = (ack_delay == 0) ? 1'b1 : (mem_req && (wcnt >= ack_delay));
  assign mem_rdata_w = mem[mem_addr_w];
  always @(posedge clk) begin
    if (mem_req && !mem_ack) wcnt <= wcnt + 1;
    else                     wcnt <= 0;
  end

  vaa_fetch_sequencer u_dut (
    .clk(clk), .reset(reset),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .ir_valid(ir_valid), .ir_ready(ir_ready), .ir_opcode(ir_opcode),
    .ir_operand(ir_operand), .ir_len(ir_len), .ir_pc(ir_pc),
    .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt), .halted(halted),
    .pc_out(pc_out), .perf_instr(perf_instr), .perf_wait(perf_wait)
  );

  vaa_fetch_sequencer #(.RESET_VECTOR(16'hFFFF)) u_dut_wrap (
    .clk(clk), .reset(reset),
    .mem_req(mem_req_w), .mem_addr(mem_addr_w), .mem_ack(1'b1), .mem_rdata(mem_rdata_w),
    .ir_valid(ir_valid_w), .ir_ready(ir_ready), .ir_opcode(ir_opcode_w),
    .ir_operand(ir_operand_w), .ir_len(ir_len_w), .ir_pc(ir_pc_w),
    .redirect(1'b0), .redirect_pc(16'h0000), .halt(1'b0), .halted(halted_w),
    .pc_out(pc_out_w), .perf_instr(perf_instr_w), .perf_wait(perf_wait_w)
  );

  task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t got=%h exp=%h", nm, $time, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 boot, 1 fetching bytes, 2 offering instruction, 3 halted
  int          m_phase = 0;
  int          m_len = 1, m_got = 0;
  logic [15:0] m_pc = '0, m_irpc = '0, m_opnd = '0;
  logic [7:0]  m_opc = '0;
  logic [31:0] m_ninstr = '0, m_nwait = '0;
  bit          chk_en = 1'b0;

  always @(posedge clk) begin
    logic [7:0] b;
    if (reset) begin
      m_phase = 0; m_pc = 16'h0000; m_got = 0;
      m_opc = '0; m_opnd = '0; m_len = 1; m_irpc = '0;
      m_ninstr = '0; m_nwait = '0;
      chk_en = 1'b1;
    end else begin
      if (m_phase == 1 && !mem_ack && m_nwait != 32'hFFFF_FFFF) m_nwait = m_nwait + 1;
      if (m_phase == 2 && ir_ready && m_ninstr != 32'hFFFF_FFFF) m_ninstr = m_ninstr + 1;
      if (m_phase == 0) begin
        m_phase = 1; m_got = 0;
      end else if (redirect) begin
        m_pc = redirect_pc; m_got = 0;
        if (m_phase != 3) m_phase = 1;
      end else if (m_phase == 1) begin
        if (mem_ack) begin
          b = mem[m_pc];
          if (m_got == 0) begin
            m_opc = b; m_irpc = m_pc; m_opnd = '0;
            m_len = b[7] ? 3 : (b[6] ? 2 : 1);
          end else if (m_got == 1) m_opnd[7:0] = b;
          else                     m_opnd[15:8] = b;
          m_pc  = m_pc + 16'd1;
          m_got = m_got + 1;
          if (m_got == m_len) begin m_phase = 2; m_got = 0; end
        end
      end else if (m_phase == 2) begin
        if (ir_ready) m_phase = halt ? 3 : 1;
      end else if (m_phase == 3) begin
        if (!halt) m_phase = 1;
      end
    end
  end

  // every-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("mem_req",    32'(mem_req),    32'(m_phase == 1));
      cmp("ir_valid",   32'(ir_valid),   32'(m_phase == 2));
      cmp("halted",     32'(halted),     32'(m_phase == 3));
      cmp("pc_out",     32'(pc_out),     32'(m_pc));
      if (m_phase == 1) cmp("mem_addr", 32'(mem_addr), 32'(m_pc));
      cmp("ir_opcode",  32'(ir_opcode),  32'(m_opc));
      cmp("ir_operand", 32'(ir_operand), 32'(m_opnd));
      cmp("ir_len",     32'(ir_len),     32'(m_len));
      cmp("ir_pc",      32'(ir_pc),      32'(m_irpc));
      cmp("perf_instr", perf_instr, PERF ? m_ninstr : 32'd0);
      cmp("perf_wait",  perf_wait,  PERF ? m_nwait  : 32'd0);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 50 && !ir_valid; i++) tick(1);
    cmp("wait_ir_valid", 32'(ir_valid), 32'd1);
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
    ir_ready = 1'b1; redirect = 1'b0; redirect_pc = 16'h0000; halt = 1'b0;
    mem[16'h0001] = 8'h40; mem[16'h0002] = 8'h55;
    mem[16'h0010] = 8'h80; mem[16'h0011] = 8'h34; mem[16'h0012] = 8'h12;
    mem[16'h0013] = 8'h40; mem[16'h0014] = 8'h99;
    mem[16'h0101] = 8'h80;

    // 1: reset state, 1-byte and 2-byte instructions, zero-wait
    do_reset();
    cmp("rst_mem_req",  32'(mem_req),   32'd0);
    cmp("rst_ir_valid", 32'(ir_valid),  32'd0);
    cmp("rst_ir_len",   32'(ir_len),    32'd1);
    cmp("rst_halted",   32'(halted),    32'd0);
    cmp("rst_pc",       32'(pc_out),    32'h0000);
    tick(1);
    cmp("t1_req",       32'(mem_req),   32'd1);
    cmp("t1_addr",      32'(mem_addr),  32'h0000);
    wait_valid();
    cmp("t1_op0",       32'(ir_opcode), 32'h00);
    cmp("t1_len0",      32'(ir_len),    32'd1);
    cmp("t1_pc0",       32'(ir_pc),     32'h0000);
    tick(1);
    wait_valid();
    cmp("t1_op1",       32'(ir_opcode), 32'h40);
    cmp("t1_opnd1",     32'(ir_operand),32'h0055);
    cmp("t1_len1",      32'(ir_len),    32'd2);
    cmp("t1_pc1",       32'(ir_pc),     32'h0001);
    cmp("t1_pcout",     32'(pc_out),    32'h0003);

    // 2: 3-byte instruction at 0010 with 2 wait cycles per word
    ir_ready = 1'b0;
    do_reset();
    tick(1);
    redirect = 1'b1; redirect_pc = 16'h0010;
    tick(1);
    redirect = 1'b0; ack_delay = 2;
    cmp("t2_addr_a",    32'(mem_addr),  32'h0010);
    tick(1);
    cmp("t2_addr_b",    32'(mem_addr),  32'h0010);
    cmp("t2_ack_low",   32'(mem_ack),   32'd0);
    wait_valid();
    cmp("t2_op",        32'(ir_opcode), 32'h80);
    cmp("t2_opnd",      32'(ir_operand),32'h1234);
    cmp("t2_len",       32'(ir_len),    32'd3);
    cmp("t2_pc",        32'(ir_pc),     32'h0010);
    cmp("t2_pcout",     32'(pc_out),    32'h0013);
    cmp("t2_perf_wait", perf_wait,      PERF ? 32'd6 : 32'd0);

    // 3: back-pressure for 5 cycles, accept on the 6th
    for (int i = 0; i < 4; i++) begin
      tick(1);
      cmp("t3_valid",   32'(ir_valid),  32'd1);
      cmp("t3_req",     32'(mem_req),   32'd0);
      cmp("t3_opnd",    32'(ir_operand),32'h1234);
    end
    ir_ready = 1'b1; ack_delay = 0;
    tick(1);
    cmp("t3_next_req",  32'(mem_req),   32'd1);
    cmp("t3_next_addr", 32'(mem_addr),  32'h0013);
    cmp("t3_perf_instr",perf_instr,     PERF ? 32'd1 : 32'd0);

    // 4: redirect in FETCH_B1 together with ack
    tick(1);
    cmp("t4_b1_addr",   32'(mem_addr),  32'h0014);
    redirect = 1'b1; redirect_pc = 16'h0100;
    tick(1);
    redirect = 1'b0;
    cmp("t4_valid",     32'(ir_valid),  32'd0);
    cmp("t4_addr",      32'(mem_addr),  32'h0100);

    // 5: halt at accept, release, then reset mid-FETCH_B2
    halt = 1'b1;
    tick(1);
    cmp("t5_op",        32'(ir_opcode), 32'h00);
    cmp("t5_irpc",      32'(ir_pc),     32'h0100);
    tick(1);
    cmp("t5_halted",    32'(halted),    32'd1);
    cmp("t5_req",       32'(mem_req),   32'd0);
    tick(3);
    cmp("t5_halted2",   32'(halted),    32'd1);
    halt = 1'b0;
    tick(1);
    cmp("t5_unhalt",    32'(halted),    32'd0);
    cmp("t5_addr",      32'(mem_addr),  32'h0101);
    tick(2);
    cmp("t5_b2_addr",   32'(mem_addr),  32'h0103);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    cmp("t5_rst_pc",    32'(pc_out),    32'h0000);
    cmp("t5_rst_req",   32'(mem_req),   32'd0);
    cmp("t5_rst_len",   32'(ir_len),    32'd1);

    // 6: RESET_VECTOR=FFFF wrap
    mem[16'hFFFF] = 8'h40; mem[16'h0000] = 8'h77;
    do_reset();
    for (int i = 0; i < 20 && !ir_valid_w; i++) tick(1);
    cmp("t6_valid",     32'(ir_valid_w),   32'd1);
    cmp("t6_op",        32'(ir_opcode_w),  32'h40);
    cmp("t6_opnd",      32'(ir_operand_w), 32'h0077);
    cmp("t6_irpc",      32'(ir_pc_w),      32'hFFFF);
    cmp("t6_pcout",     32'(pc_out_w),     32'h0001);

    // 7: redirect coinciding with an accept
    wait_valid();
    redirect = 1'b1; redirect_pc = 16'h0200;
    tick(1);
    redirect = 1'b0;
    cmp("t7_valid",     32'(ir_valid),  32'd0);
    cmp("t7_addr",      32'(mem_addr),  32'h0200);
    tick(6);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t got=running exp=finished", $time);
    $fatal(1);
  end

endmodule

// File: doc/vaa_fetch_sequencer.md
Name: vaa_fetch_sequencer

Overview:
Parametrised multi-byte instruction fetch sequencer. It replaces the single-byte, every-cycle instruction register load with a handshaked fetch of an opcode plus 0–2 operand bytes. It holds the program counter and issues one complete instruction per valid/ready transfer to the decoder and execute stage. It also supports branch redirection and halting.

Parameters:
DATA_W, 8, width of a memory word, opcode and each operand byte.
ADDR_W, 16, program counter and memory address width.
RESET_VECTOR, 0, PC value loaded on reset (ADDR_W bits).

Ports:
clk  in  1  clock.
reset  in  1  synchronous, active-high reset.
mem_req  out  1  fetch request, held until acknowledged.
mem_addr  out  ADDR_W  fetch address; stable while mem_req=1.
mem_ack  in  1  memory accepted request; mem_rdata valid this cycle.
mem_rdata  in  DATA_W  fetched word.
ir_valid  out  1  complete instruction available.
ir_ready  in  1  decoder/execute accepts instruction.
ir_opcode  out  DATA_W  opcode byte.
ir_operand  out  2*DATA_W  operands; first byte in [DATA_W-1:0], second in upper half.
ir_len  out  2  instruction length in bytes (1..3).
ir_pc  out  ADDR_W  address of the opcode byte.
redirect  in  1  branch/jump: restart fetch at redirect_pc.
redirect_pc  in  ADDR_W  redirect target.
halt  in  1  level; stop at the next instruction boundary.
halted  out  1  sequencer is in HALTED.
pc_out  out  ADDR_W  current PC, for debug.
perf_instr  out  32  instructions issued (optional feature).
perf_wait  out  32  memory wait cycles (optional feature).

Behaviour:
- Reset: synchronous to clk; one clock with reset=1 is sufficient.
  - Sets pc=RESET_VECTOR and state=BOOT.
  - Outputs: mem_req=0, ir_valid=0, ir_opcode/ir_operand/ir_pc=0, ir_len=1, halted=0, perf counters=0.
  - A reset mid-fetch abandons that fetch; a late mem_ack is ignored.
- States: BOOT, FETCH_OP, FETCH_B1, FETCH_B2, ISSUE, HALTED.
- mem_req is 1 exactly in the FETCH_* states, and mem_addr=pc.
- BOOT: one cycle, all outputs inactive, then go to FETCH_OP.
- Transfer rule: a word transfers on mem_req&mem_ack. On transfer, capture mem_rdata and set pc=pc+1 modulo 2^ADDR_W (FFFF wraps to 0000). mem_ack while mem_req=0 is ignored.
- Length decode uses the opcode's top 2 bits: 00 means 1 byte, 01 means 2 bytes, 1x means 3 bytes.
- FETCH_OP: on transfer, latch ir_opcode, ir_pc=old pc and ir_len. Clear ir_operand. Go to ISSUE (1-byte) or FETCH_B1.
- FETCH_B1: on transfer, latch the low operand. Go to ISSUE (2-byte) or FETCH_B2.
- FETCH_B2: on transfer, latch the high operand, then go to ISSUE.
- ISSUE: ir_valid=1 and all ir_* fields held stable until ir_valid&ir_ready. No mem_req in ISSUE.
  - On accept, go to HALTED if halt=1, else FETCH_OP.
- HALTED: halted=1 and mem_req=0. Leave for FETCH_OP on the first cycle halt=0. halt is not sampled in any other state.
- Redirect: highest priority after reset, in any state except BOOT.
  - Sets pc=redirect_pc and drops ir_valid the next cycle.
  - Data acked in the same cycle is discarded.
  - Next state is FETCH_OP, or HALTED if currently HALTED.
  - Redirect coinciding with an ISSUE accept: the instruction counts as consumed, and the next fetch is from redirect_pc.
- Latency with zero-wait memory (ack in the request cycle): N-byte instruction issues N cycles after its first request. Minimum throughput is (N+1) cycles per instruction with ir_ready=1.

Optional Feature:
Macro VAA_FETCH_PERF_EN.
- Defined:
  - perf_instr increments on each ISSUE accept.
  - perf_wait increments each cycle with mem_req=1 and mem_ack=0.
  - Both counters are 32-bit, saturate at FFFFFFFF and clear on reset.
- Undefined: both ports remain and are tied to 0; no counter logic is synthesised.

Test Plan:
1. Memory 0000:00, 0001:40 0002:55, zero-wait, ir_ready=1 -> after BOOT, first mem_addr=0000; issue opcode 00, len 1, ir_pc 0000. Then opcode 40, operand 0055, len 2, ir_pc 0001. pc_out=0003.
2. Opcode 80 at 0010 with 34, 12 following; mem_ack delayed 2 cycles per word -> mem_addr stable through each wait. Issue ir_operand 1234, ir_len 3. perf_wait=6 with VAA_FETCH_PERF_EN defined, 0 without.
3. ir_ready low for 5 cycles in ISSUE -> ir_valid=1 with unchanged fields, mem_req=0. Accept on the 6th cycle, then the next request is at the following pc.
4. redirect=1, redirect_pc=0100 in FETCH_B1, same cycle as mem_ack -> byte discarded, ir_valid stays 0, next mem_addr=0100.
5. halt=1 at accept -> halted=1, mem_req=0 for the whole halt. Release halt -> FETCH_OP at the next pc. Reset asserted mid-FETCH_B2 -> BOOT, pc=RESET_VECTOR.
6. RESET_VECTOR=FFFF, opcode 40 at FFFF -> operand fetched from 0000, ir_pc FFFF, pc_out 0001.
